// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the neural-network layer sequencer.
package nn_seq_pkg;

    // Width of the shared phase/timeout counter
    localparam int TW = 16;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE,
        LRST_FILL,
        FILL,
        LRST_RUN,
        RUN,
        DONE,
        ERR
    } seq_state_t;

    // Width of a layer index; never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control bus between the sequencer and the chained layer datapaths.
interface nn_layer_sequencer_if
    import nn_seq_pkg::*;
#(
    parameter int NUM_LAYERS = 2
);
    localparam int IW = idx_w(NUM_LAYERS);

    logic                  layer_rst;
    logic                  fill;
    logic [NUM_LAYERS-1:0] layer_req;
    logic [NUM_LAYERS-1:0] layer_ack;
    logic [IW-1:0]         layer_idx;

    modport master (
        output layer_rst,
        output fill,
        output layer_req,
        output layer_idx,
        input  layer_ack
    );

    modport slave (
        input  layer_rst,
        input  fill,
        input  layer_req,
        input  layer_idx,
        output layer_ack
    );

endinterface

// File: rtl/nn_seq_timer.sv
// Phase timer: counts cycles while enabled and flags when the count
// equals a programmable limit. Saturates instead of wrapping.
module nn_seq_timer
    import nn_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] limit,
    output logic          expired
);

    logic [TW-1:0] cnt;

    // Cycle counter; clear has priority over counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expired = (cnt == limit);

endmodule

// File: rtl/nn_layer_sequencer.sv
// Control sequencer for a chain of NN layer datapaths: loads weights via
// the broadcast fill strobe, resets layer address counters before every
// phase, then walks the layers in order using their req/ack handshake.
// All outputs are registered decodes of the current state, so they trail
// the state register by one cycle.
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int NUM_LAYERS  = 2,
    parameter int FILL_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        cfg_load,
    nn_layer_sequencer_if.master        lbus,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        cfg_valid
);

    localparam int IW = idx_w(NUM_LAYERS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LAYERS - 1);

    seq_state_t            state;
    logic [IW-1:0]         idx;
    logic                  cfg_loaded;
    logic [NUM_LAYERS-1:0] ack_hist;

    logic [NUM_LAYERS-1:0] ack_rise_vec;
    logic                  ack_rise;
    logic [NUM_LAYERS-1:0] req_onehot;
    logic                  tmr_clr;
    logic                  tmr_en;
    logic [TW-1:0]         tmr_limit;
    logic                  tmr_expired;

    // Ack edge detection, request decode and timer control from current state
    always_comb begin
        ack_rise_vec    = lbus.layer_ack & ~ack_hist;
        ack_rise        = ack_rise_vec[idx];
        req_onehot      = '0;
        req_onehot[idx] = 1'b1;
        tmr_clr         = (state == LRST_FILL) || (state == LRST_RUN) ||
                          ((state == RUN) && ack_rise);
        tmr_en          = (state == FILL) || (state == RUN);
        tmr_limit       = (state == FILL) ? TW'(FILL_CYCLES - 1) : TW'(TIMEOUT);
    end

    nn_seq_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .limit   (tmr_limit),
        .expired (tmr_expired)
    );

    // Sequencer FSM with registered outputs and ack history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            cfg_loaded     <= 1'b0;
            ack_hist       <= '0;
            lbus.layer_rst <= 1'b0;
            lbus.fill      <= 1'b0;
            lbus.layer_req <= '0;
            lbus.layer_idx <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            cfg_valid      <= 1'b0;
        end else begin
            ack_hist       <= lbus.layer_ack;

            lbus.layer_rst <= (state == LRST_FILL) || (state == LRST_RUN);
            lbus.fill      <= (state == FILL);
            lbus.layer_req <= (state == RUN) ? req_onehot : '0;
            lbus.layer_idx <= idx;
            busy           <= (state != IDLE) && (state != ERR);
            done           <= (state == DONE);
            error          <= (state == ERR);
            cfg_valid      <= cfg_loaded;

            case (state)
                // Requests are only honoured once the busy output has dropped,
                // so the cycle right after a phase ends cannot retrigger.
                IDLE, ERR: begin
                    if (!busy) begin
                        if (cfg_load) begin
                            state <= LRST_FILL;
                        end else if (start && cfg_valid) begin
                            idx   <= '0;
                            state <= LRST_RUN;
                        end
                    end
                end
                LRST_FILL: begin
                    state <= FILL;
                end
                FILL: begin
                    if (tmr_expired) begin
                        cfg_loaded <= 1'b1;
                        state      <= IDLE;
                    end
                end
                LRST_RUN: begin
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (ack_rise) begin
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else if (tmr_expired) begin
                        state <= ERR;
                    end
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer (NUM_LAYERS=2, FILL_CYCLES=2, TIMEOUT=20).
module tb_nn_layer_sequencer;

    localparam int NL = 2;
    localparam int FC = 2;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cfg_load = 1'b0;
    logic busy;
    logic done;
    logic error;
    logic cfg_valid;

    int checks = 0;
    int errors = 0;

    nn_layer_sequencer_if #(.NUM_LAYERS(NL)) lbus ();

    nn_layer_sequencer #(
        .NUM_LAYERS  (NL),
        .FILL_CYCLES (FC),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_load  (cfg_load),
        .lbus      (lbus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cfg_valid (cfg_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed compare of {layer_rst, fill, layer_req, layer_idx, busy, done, error, cfg_valid}
    task automatic outs(input string tag, input logic lr, input logic fl,
                        input logic [1:0] rq, input logic ix, input logic bz,
                        input logic dn, input logic er, input logic cv);
        chk(tag,
            32'({lbus.layer_rst, lbus.fill, lbus.layer_req, lbus.layer_idx,
                 busy, done, error, cfg_valid}),
            32'({lr, fl, rq, ix, bz, dn, er, cv}));
    endtask

    initial begin
        lbus.layer_ack = '0;

        // Reset state
        tick(2);
        outs("reset_state", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // Start before any load is ignored
        start = 1'b1;
        tick(3);
        outs("start_no_cfg", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        start = 1'b0;

        // Load sequence: cfg_load sampled at E0
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        outs("load_e0", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        tick();
        outs("load_lrst_e1", 1, 0, 2'b00, 0, 1, 0, 0, 0);
        tick();
        outs("load_fill_e2", 0, 1, 2'b00, 0, 1, 0, 0, 0);
        tick();
        outs("load_fill_e3", 0, 1, 2'b00, 0, 1, 0, 0, 0);
        tick();
        outs("load_end_e4", 0, 0, 2'b00, 0, 0, 0, 0, 1);

        // Inference: ack0 five cycles after req0, ack1 seven cycles after req1
        start = 1'b1;
        tick();
        start = 1'b0;
        outs("run_e0", 0, 0, 2'b00, 0, 0, 0, 0, 1);
        tick();
        outs("run_lrst_e1", 1, 0, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("run_req0_e2", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        tick(4);
        outs("run_req0_e6", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        lbus.layer_ack = 2'b01;
        tick();
        outs("run_req0_e7", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        tick();
        outs("run_req1_e8", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        tick(6);
        outs("run_req1_e14", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        lbus.layer_ack = 2'b11;
        tick();
        outs("run_req1_e15", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        tick();
        outs("run_done_e16", 0, 0, 2'b00, 1, 1, 1, 0, 1);
        tick();
        outs("run_idle_e17", 0, 0, 2'b00, 0, 0, 0, 0, 1);

        // Stale ack: ack1 still high from the previous run
        lbus.layer_ack = 2'b10;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        outs("stale_req0", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        lbus.layer_ack = 2'b11;
        tick(2);
        outs("stale_req1", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        tick(5);
        outs("stale_hold", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        lbus.layer_ack = 2'b01;
        tick();
        outs("stale_drop", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        lbus.layer_ack = 2'b11;
        tick();
        outs("stale_rise", 0, 0, 2'b10, 1, 1, 0, 0, 1);
        tick();
        outs("stale_done", 0, 0, 2'b00, 1, 1, 1, 0, 1);
        tick();
        outs("stale_idle", 0, 0, 2'b00, 0, 0, 0, 0, 1);

        // Asynchronous reset in the middle of RUN
        lbus.layer_ack = 2'b00;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        outs("areset_pre", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        #1;
        rst = 1'b0;
        #1;
        outs("areset_now", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick(3);
        outs("areset_start_ign", 0, 0, 2'b00, 0, 0, 0, 0, 0);
        start = 1'b0;

        // Reload
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick(4);
        outs("reload_end", 0, 0, 2'b00, 0, 0, 0, 0, 1);

        // Timeout: layer 0 never acks
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        outs("to_req0_e2", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        tick(20);
        outs("to_req0_e22", 0, 0, 2'b01, 0, 1, 0, 0, 1);
        tick();
        outs("to_err_e23", 0, 0, 2'b00, 0, 0, 0, 1, 1);
        tick();
        outs("to_err_sticky", 0, 0, 2'b00, 0, 0, 0, 1, 1);
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        outs("err_load_e0", 0, 0, 2'b00, 0, 0, 0, 1, 1);
        tick();
        outs("err_load_lrst", 1, 0, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("err_load_fill1", 0, 1, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("err_load_fill2", 0, 1, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("err_load_end", 0, 0, 2'b00, 0, 0, 0, 0, 1);

        // Simultaneous start and cfg_load: load wins, no inference
        start = 1'b1;
        cfg_load = 1'b1;
        tick();
        start = 1'b0;
        cfg_load = 1'b0;
        tick();
        outs("both_lrst", 1, 0, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("both_fill1", 0, 1, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("both_fill2", 0, 1, 2'b00, 0, 1, 0, 0, 1);
        tick();
        outs("both_end", 0, 0, 2'b00, 0, 0, 0, 0, 1);
        tick(3);
        outs("both_quiet", 0, 0, 2'b00, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Control block that sequences a chain of neural-network layer datapaths (hidden layer, output layer, ...) for one inference.
- Loads each layer's weight and bias storage by pulsing the shared `fill` line.
- Issues a local synchronous reset to the layers before each phase, so their read/write address counters restart.
- Then walks the layers in order, using each layer's req/ack handshake.
- Sits between the system-level start/config interface and the layer instances; it holds no datapath of its own.

## Interface
Parameters:
- NUM_LAYERS, 2, number of chained layer datapaths (≥1)
- FILL_CYCLES, 2, cycles `fill` is held high per load (one weight/bias word per layer per cycle)
- TIMEOUT, 255, maximum cycles to wait for one layer's ack (1..65535)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request one inference; sampled in IDLE or ERR
- cfg_load  in  1  request weight/bias reload; sampled in IDLE or ERR
- layer_rst  out  1  one-cycle active-high synchronous reset to all layers
- fill  out  1  broadcast fill strobe to all layers
- layer_req  out  NUM_LAYERS  one-hot request to layer k
- layer_ack  in  NUM_LAYERS  completion from layer k (level, may stay high)
- layer_idx  out  max(1,$clog2(NUM_LAYERS))  index of active layer
- busy  out  1  high in every state except IDLE and ERR
- done  out  1  one-cycle pulse at inference completion
- error  out  1  sticky timeout flag
- cfg_valid  out  1  weights loaded at least once since reset

## Operation
- Reset (rst=0, asynchronous) forces the following, plus timer=0 and the ack history register=0:
  - state IDLE
  - every output 0, including layer_req, layer_idx, cfg_valid and error
- FSM states: IDLE, LRST_FILL, FILL, LRST_RUN, RUN, DONE, ERR.
- IDLE:
  - cfg_load=1 → LRST_FILL. cfg_load wins if start is high in the same cycle.
  - Else start=1 and cfg_valid=1 → LRST_RUN.
  - start with cfg_valid=0 is ignored: no state change, no flag.
- LRST_FILL: layer_rst=1 for one cycle → FILL.
- FILL:
  - fill=1 for exactly FILL_CYCLES cycles, counted by the timer → IDLE.
  - cfg_valid is set on exit.
- LRST_RUN: layer_rst=1 for one cycle, layer_idx=0 → RUN.
- RUN:
  - layer_req[layer_idx]=1, all other req bits 0.
  - Completion is a rising edge of layer_ack[layer_idx]: current sample high, previous sample low. A level that is already high does not count.
  - On completion with layer_idx<NUM_LAYERS-1: increment layer_idx, clear the timer, stay in RUN.
  - On completion of the last layer → DONE.
  - If the timer reaches TIMEOUT without completion → ERR.
- DONE: done=1 and layer_req=0 for one cycle → IDLE. layer_idx returns to 0.
- ERR:
  - error=1, layer_req=0, busy=0.
  - cfg_load → LRST_FILL; otherwise start with cfg_valid=1 → LRST_RUN. Either exit clears error on the transition.
- start and cfg_load are ignored while busy=1.
- The ack history register samples layer_ack every cycle, in every state.

## Timing
- Notation: start sampled high at edge 0.
  - layer_rst is high in cycle 1.
  - layer_req[0] rises at edge 2.
- Ack edge for layer k sampled at edge t:
  - layer_req[k] falls at t+1.
  - layer_req[k+1] rises at t+1.
  - No gap cycle and no overlap between requests.
- Last ack edge sampled at edge t: done is high in cycle t+1; busy falls at t+2.
- Load latency:
  - cfg_load at edge 0 → layer_rst in cycle 1.
  - fill in cycles 2..FILL_CYCLES+1.
  - cfg_valid=1 and busy=0 from edge FILL_CYCLES+2.
- Timeout:
  - The timer is 16-bit; it clears on every RUN entry and on every layer advance.
  - It increments each RUN cycle.
  - ERR is entered on the edge after the timer equals TIMEOUT.
- Async reset mid-operation clears outputs immediately, without waiting for a clock edge.
- The first clock edge after reset release is treated as IDLE.

## Structure
- Package nn_seq_pkg holds:
  - the state enum seq_state_t
  - the timer width constant TW=16
  - the layer index width function
- One sub-module, nn_seq_timer: 16-bit counter with clear, enable and an `expired` compare against a programmable limit. It is shared by FILL (limit FILL_CYCLES-1) and RUN (limit TIMEOUT).
- The FSM, ack edge detection and output decode stay in the top module.

## Test plan
1. Reset: assert rst=0 mid-RUN with layer_req=01 → all outputs 0 with no clock edge. After release, start is ignored until cfg_valid=1.
2. Load, with FILL_CYCLES=2: cfg_load at edge 0 → layer_rst in cycle 1, fill in cycles 2–3, cfg_valid=1 and busy=0 from edge 4.
3. Inference, with NUM_LAYERS=2:
   - Layer 0 ack rises 5 cycles after req; layer 1 ack rises 7 cycles after req.
   - Required: req 01 → 10 handover with no gap, done pulse exactly one cycle, layer_idx back to 0.
4. Stale ack: hold layer_ack[1]=1 from a previous run before layer 1 is requested → no advance until ack drops and rises again.
5. Timeout, with TIMEOUT=20: never ack layer 0 → error=1 after 21 RUN cycles, req=0, busy=0. A following cfg_load clears error and performs a normal load.
6. Simultaneous start and cfg_load in IDLE → load sequence runs, start is dropped, and no done pulse occurs.
